tetris_move_sched: RTL and testbench

- Move scheduler and sequencer for the active falling piece in the Tetris VGA design.
- Collects one-cycle move requests from keyboard decode (left/right/rotate/down) and the 10 Hz gravity tick, and arbitrates them onto a single shared collision-check port.
- Commits accepted moves to the piece position registers and sequences lock, respawn and game-over through the field-update port.
- Its piece position feeds the field writer that drives the 400-bit VGA field.

---
 rtl/tetris_pkg.sv | 49 ++++
 rtl/move_req_arbiter.sv | 52 +++++
 rtl/tetris_move_sched.sv | 215 +++++++++++++++++++++
 tb/tb_tetris_move_sched.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_pkg
//  Description : Shared types and widths for the Tetris move scheduler:
//                FSM state encoding, request source tags and field widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    localparam int ROW_W = 5;
    localparam int COL_W = 5;
    localparam int ROT_W = 2;
    localparam int N_SRC = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_LOCK     = 3'd2,
        ST_SPAWN    = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_t;

    // Pending-flag index equals the tag value for the five input sources.
    typedef enum logic [2:0] {
        SRC_GRAV  = 3'd0,
        SRC_ROT   = 3'd1,
        SRC_LEFT  = 3'd2,
        SRC_RIGHT = 3'd3,
        SRC_DOWN  = 3'd4,
        SRC_SPAWN = 3'd5
    } src_t;

    // One-hot pending-flag mask for a source; the spawn tag owns no flag.
    function automatic logic [N_SRC-1:0] src_mask(input src_t s);
        logic [N_SRC-1:0] m;
        m = '0;
        case (s)
            SRC_GRAV:  m[0] = 1'b1;
            SRC_ROT:   m[1] = 1'b1;
            SRC_LEFT:  m[2] = 1'b1;
            SRC_RIGHT: m[3] = 1'b1;
            SRC_DOWN:  m[4] = 1'b1;
            default:   m    = '0;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/move_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : move_req_arbiter
//  Description : Sticky pending flags for gravity/rotate/left/right/down with
//                fixed-priority winner select and per-source clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module move_req_arbiter
    import tetris_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic [N_SRC-1:0] req_pulse,
    input  logic             req_block,
    input  logic [N_SRC-1:0] clr_one,
    input  logic             clr_all,
    output logic             any_pending,
    output src_t             win_src
);

    logic [N_SRC-1:0] r_pend;
    logic [N_SRC-1:0] w_set;
    logic [N_SRC-1:0] w_clr;

    // Set and clear masks; pulses are dropped while blocked (game over).
    always_comb begin
        w_set = req_block ? '0 : req_pulse;
        w_clr = clr_all ? '1 : clr_one;
    end

    // Clear first, then OR in new pulses so a coincident set survives.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end

    // Fixed priority: gravity > rotate > left > right > down.
    always_comb begin
        any_pending = |r_pend;
        win_src     = SRC_GRAV;
        if (r_pend[0])      win_src = SRC_GRAV;
        else if (r_pend[1]) win_src = SRC_ROT;
        else if (r_pend[2]) win_src = SRC_LEFT;
        else if (r_pend[3]) win_src = SRC_RIGHT;
        else if (r_pend[4]) win_src = SRC_DOWN;
    end

endmodule
`default_nettype wire

// File: rtl/tetris_move_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_move_sched
//  Description : Serialises move requests onto the shared collision-check
//                port, commits accepted moves and sequences lock, respawn
//                and game-over for the active falling piece.
//  Revision    : 1.0 - initial release
// ============================================================================
module tetris_move_sched
    import tetris_pkg::*;
#(
    parameter int COLS        = 20,
    parameter int ROWS        = 20,
    parameter int SPAWN_COL   = 8,
    parameter int CHK_TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             key_left,
    input  logic             key_right,
    input  logic             key_rotate,
    input  logic             key_down,
    input  logic             tick_gravity,
    output logic             chk_req,
    output logic [ROW_W-1:0] chk_row,
    output logic [COL_W-1:0] chk_col,
    output logic [ROT_W-1:0] chk_rot,
    input  logic             chk_done,
    input  logic             chk_ok,
    output logic             lock_req,
    input  logic             lock_done,
    output logic [ROW_W-1:0] piece_row,
    output logic [COL_W-1:0] piece_col,
    output logic [ROT_W-1:0] piece_rot,
    output logic             busy,
    output logic             game_over,
    output logic             chk_err
);

    localparam int c_ROW_X = ROW_W + 1;
    localparam int c_COL_X = COL_W + 1;
    localparam int c_TMO_W = $clog2(CHK_TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(CHK_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    src_t               r_src;
    logic [c_TMO_W-1:0] r_tmo;
    logic [ROW_W-1:0]   r_chk_row;
    logic [COL_W-1:0]   r_chk_col;
    logic [ROT_W-1:0]   r_chk_rot;
    logic [ROW_W-1:0]   r_piece_row;
    logic [COL_W-1:0]   r_piece_col;
    logic [ROT_W-1:0]   r_piece_rot;
    logic               r_chk_err;

    logic               w_any;
    src_t               w_win;
    logic [N_SRC-1:0]   w_clr_one;
    logic               w_clr_all;
    logic [ROW_W:0]     w_cand_row;
    logic [COL_W:0]     w_cand_col;
    logic [ROT_W-1:0]   w_cand_rot;
    logic               w_cand_oob;
    logic               w_issue;
    logic               w_spawn;
    logic               w_commit;
    logic               w_tmo_hit;

    move_req_arbiter u_arb (
        .clock       (clock),
        .resetn      (resetn),
        .req_pulse   ({key_down, key_right, key_left, key_rotate, tick_gravity}),
        .req_block   (r_state == ST_GAMEOVER),
        .clr_one     (w_clr_one),
        .clr_all     (w_clr_all),
        .any_pending (w_any),
        .win_src     (w_win)
    );

    // Candidate one step away from the committed piece, one bit wider so
    // that a left move from column 0 wraps high and fails the bound test.
    always_comb begin
        w_cand_row = {1'b0, r_piece_row};
        w_cand_col = {1'b0, r_piece_col};
        w_cand_rot = r_piece_rot;
        case (w_win)
            SRC_GRAV, SRC_DOWN: w_cand_row = {1'b0, r_piece_row} + c_ROW_X'(1);
            SRC_ROT:            w_cand_rot = r_piece_rot + ROT_W'(1);
            SRC_LEFT:           w_cand_col = {1'b0, r_piece_col} - c_COL_X'(1);
            SRC_RIGHT:          w_cand_col = {1'b0, r_piece_col} + c_COL_X'(1);
            default:            ;
        endcase
        w_cand_oob = (w_cand_col >= c_COL_X'(COLS)) || (w_cand_row >= c_ROW_X'(ROWS));
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_clr_one   = '0;
        w_clr_all   = 1'b0;
        w_issue     = 1'b0;
        w_spawn     = 1'b0;
        w_commit    = 1'b0;
        w_tmo_hit   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    if (w_cand_oob) begin
                        if (w_win == SRC_GRAV || w_win == SRC_DOWN) begin
                            w_state_nxt = ST_LOCK;
                            w_clr_all   = 1'b1;
                        end else begin
                            w_clr_one = src_mask(w_win);
                        end
                    end else begin
                        w_issue     = 1'b1;
                        w_state_nxt = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                w_tmo_hit = !chk_done && (r_tmo == c_TMO_LAST);
                if (chk_done || w_tmo_hit) begin
                    w_clr_one = src_mask(r_src);
                    if (chk_done && chk_ok) begin
                        w_commit    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (r_src == SRC_SPAWN) begin
                        w_state_nxt = ST_GAMEOVER;
                    end else if (r_src == SRC_GRAV || r_src == SRC_DOWN) begin
                        w_state_nxt = ST_LOCK;
                        w_clr_all   = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_LOCK: begin
                if (lock_done) begin
                    w_state_nxt = ST_SPAWN;
                end
            end
            ST_SPAWN: begin
                w_spawn     = 1'b1;
                w_state_nxt = ST_CHECK;
            end
            ST_GAMEOVER: ;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Candidate, committed piece, check timer and sticky error.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_src       <= SRC_GRAV;
            r_tmo       <= '0;
            r_chk_row   <= '0;
            r_chk_col   <= '0;
            r_chk_rot   <= '0;
            r_piece_row <= '0;
            r_piece_col <= COL_W'(SPAWN_COL);
            r_piece_rot <= '0;
            r_chk_err   <= 1'b0;
        end else begin
            r_tmo <= (r_state == ST_CHECK) ? r_tmo + c_TMO_W'(1) : '0;
            if (w_tmo_hit) begin
                r_chk_err <= 1'b1;
            end
            if (w_issue) begin
                r_chk_row <= w_cand_row[ROW_W-1:0];
                r_chk_col <= w_cand_col[COL_W-1:0];
                r_chk_rot <= w_cand_rot;
                r_src     <= w_win;
            end
            if (w_spawn) begin
                r_chk_row   <= '0;
                r_chk_col   <= COL_W'(SPAWN_COL);
                r_chk_rot   <= '0;
                r_piece_row <= '0;
                r_piece_col <= COL_W'(SPAWN_COL);
                r_piece_rot <= '0;
                r_src       <= SRC_SPAWN;
            end
            if (w_commit) begin
                r_piece_row <= r_chk_row;
                r_piece_col <= r_chk_col;
                r_piece_rot <= r_chk_rot;
            end
        end
    end

    assign chk_req   = (r_state == ST_CHECK);
    assign lock_req  = (r_state == ST_LOCK);
    assign busy      = (r_state != ST_IDLE);
    assign game_over = (r_state == ST_GAMEOVER);
    assign chk_err   = r_chk_err;
    assign chk_row   = r_chk_row;
    assign chk_col   = r_chk_col;
    assign chk_rot   = r_chk_rot;
    assign piece_row = r_piece_row;
    assign piece_col = r_piece_col;
    assign piece_rot = r_piece_rot;

endmodule
`default_nettype wire

// File: tb/tb_tetris_move_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tetris_move_sched
//  Description : Self-checking bench for tetris_move_sched: behavioural
//                model, per-cycle compare, directed and random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tetris_move_sched;

    localparam int COLS        = 20;
    localparam int ROWS        = 20;
    localparam int SPAWN_COL   = 8;
    localparam int CHK_TIMEOUT = 64;

    localparam int M_IDLE = 0, M_CHECK = 1, M_LOCK = 2, M_SPAWN = 3, M_OVER = 4;
    localparam int S_SPAWN = 5;
    localparam bit [4:0] K_GRAV = 5'b00001, K_ROT = 5'b00010, K_LEFT = 5'b00100,
                         K_RIGHT = 5'b01000, K_DOWN = 5'b10000;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic key_left = 1'b0, key_right = 1'b0, key_rotate = 1'b0, key_down = 1'b0;
    logic tick_gravity = 1'b0;
    logic chk_done = 1'b0, chk_ok = 1'b0, lock_done = 1'b0;
    logic chk_req, lock_req, busy, game_over, chk_err;
    logic [4:0] chk_row, chk_col, piece_row, piece_col;
    logic [1:0] chk_rot, piece_rot;

    always #5 clock = ~clock;

    tetris_move_sched #(
        .COLS(COLS), .ROWS(ROWS), .SPAWN_COL(SPAWN_COL), .CHK_TIMEOUT(CHK_TIMEOUT)
    ) dut (
        .clock(clock), .resetn(resetn),
        .key_left(key_left), .key_right(key_right), .key_rotate(key_rotate),
        .key_down(key_down), .tick_gravity(tick_gravity),
        .chk_req(chk_req), .chk_row(chk_row), .chk_col(chk_col), .chk_rot(chk_rot),
        .chk_done(chk_done), .chk_ok(chk_ok),
        .lock_req(lock_req), .lock_done(lock_done),
        .piece_row(piece_row), .piece_col(piece_col), .piece_rot(piece_rot),
        .busy(busy), .game_over(game_over), .chk_err(chk_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: what the scheduler is doing this cycle.
    int     m_mode = M_IDLE, m_age = 0;
    int     m_row = 0, m_col = SPAWN_COL, m_rot = 0;
    int     c_row = 0, c_col = 0, c_rot = 0, c_src = 0;
    bit [4:0] m_pend = '0;
    bit     m_err = 1'b0;

    // Responder policy (percentages and delay ranges) and per-transaction picks.
    int pol_delay_max = 0, pol_timeout_pct = 0, pol_ok_pct = 100;
    int pol_spawn_ok_pct = 100, pol_lock_max = 0;
    int r_tgt = 0, l_tgt = 0;
    bit r_okv = 1'b1;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge from this cycle's inputs.
    task automatic model_step();
        bit [4:0] pulses;
        bit [4:0] clr;
        int nmode, w, r, c, o;
        bit timeout, ok;
        pulses = {key_down, key_right, key_left, key_rotate, tick_gravity};
        clr    = '0;
        nmode  = m_mode;
        if (m_mode == M_IDLE && m_pend != 0) begin
            w = 0;
            for (int i = 4; i >= 0; i--) if (m_pend[i]) w = i;
            r = m_row; c = m_col; o = m_rot;
            if (w == 0 || w == 4) r = r + 1;
            else if (w == 1) o = (o + 1) % 4;
            else if (w == 2) c = c - 1;
            else c = c + 1;
            if (c < 0 || c >= COLS || r >= ROWS) begin
                if (w == 0 || w == 4) begin nmode = M_LOCK; clr = '1; end
                else clr[w] = 1'b1;
            end else begin
                c_row = r; c_col = c; c_rot = o; c_src = w;
                nmode = M_CHECK;
            end
        end else if (m_mode == M_CHECK) begin
            timeout = !chk_done && (m_age + 1 == CHK_TIMEOUT);
            if (chk_done || timeout) begin
                ok = chk_done && chk_ok;
                if (timeout) m_err = 1'b1;
                if (c_src < 5) clr[c_src] = 1'b1;
                if (ok) begin
                    m_row = c_row; m_col = c_col; m_rot = c_rot;
                    nmode = M_IDLE;
                end else if (c_src == S_SPAWN) nmode = M_OVER;
                else if (c_src == 0 || c_src == 4) begin nmode = M_LOCK; clr = '1; end
                else nmode = M_IDLE;
            end
        end else if (m_mode == M_LOCK) begin
            if (lock_done) nmode = M_SPAWN;
        end else if (m_mode == M_SPAWN) begin
            m_row = 0; m_col = SPAWN_COL; m_rot = 0;
            c_row = 0; c_col = SPAWN_COL; c_rot = 0; c_src = S_SPAWN;
            nmode = M_CHECK;
        end
        if (m_mode != M_OVER) m_pend = (m_pend & ~clr) | pulses;
        m_age  = (nmode != m_mode) ? 0 : m_age + 1;
        m_mode = nmode;
    endtask

    initial forever begin
        @(posedge clock or negedge resetn);
        if (!resetn) begin
            m_mode = M_IDLE; m_age = 0; m_row = 0; m_col = SPAWN_COL; m_rot = 0;
            m_pend = '0; m_err = 1'b0;
        end else begin
            model_step();
        end
    end

    // Per-cycle compare of every output against the model.
    initial forever begin
        @(negedge clock);
        if (cmp_en) begin
            chk("chk_req",   chk_req,   m_mode == M_CHECK);
            chk("lock_req",  lock_req,  m_mode == M_LOCK);
            chk("busy",      busy,      m_mode != M_IDLE);
            chk("game_over", game_over, m_mode == M_OVER);
            chk("chk_err",   chk_err,   m_err);
            chk("piece_row", piece_row, m_row);
            chk("piece_col", piece_col, m_col);
            chk("piece_rot", piece_rot, m_rot);
            if (m_mode == M_CHECK) begin
                chk("chk_row", chk_row, c_row);
                chk("chk_col", chk_col, c_col);
                chk("chk_rot", chk_rot, c_rot);
            end
        end
    end

    // Collision checker / lock responder, driven from the model's view.
    task automatic respond();
        chk_done  = 1'b0;
        chk_ok    = 1'($urandom);
        lock_done = 1'b0;
        if (m_mode == M_CHECK) begin
            if (m_age == 0) begin
                if (int'($urandom_range(0, 99)) < pol_timeout_pct) r_tgt = 1000;
                else r_tgt = int'($urandom_range(0, pol_delay_max));
                if (c_src == S_SPAWN) r_okv = int'($urandom_range(0, 99)) < pol_spawn_ok_pct;
                else r_okv = int'($urandom_range(0, 99)) < pol_ok_pct;
            end
            if (m_age == r_tgt) begin
                chk_done = 1'b1;
                chk_ok   = r_okv;
            end
        end
        if (m_mode == M_LOCK) begin
            if (m_age == 0) l_tgt = int'($urandom_range(0, pol_lock_max));
            lock_done = (m_age == l_tgt);
        end
    endtask

    task automatic tick(input bit [4:0] k);
        @(posedge clock);
        #1;
        {key_down, key_right, key_left, key_rotate, tick_gravity} = k;
        respond();
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        resetn = 1'b0;
        {key_down, key_right, key_left, key_rotate, tick_gravity} = '0;
        chk_done = 1'b0; lock_done = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        respond();
    endtask

    task automatic set_directed();
        pol_delay_max = 0; pol_timeout_pct = 0; pol_ok_pct = 100;
        pol_spawn_ok_pct = 100; pol_lock_max = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit saw;
        int cnt;
        bit done;
        set_directed();
        @(posedge clock);
        cmp_en = 1'b1;
        do_reset();

        // Reset values and a first move right with immediate ok.
        tick(0); @(negedge clock);
        chk("rst_piece_row", piece_row, 0);
        chk("rst_piece_col", piece_col, 8);
        chk("rst_piece_rot", piece_rot, 0);
        chk("rst_busy", busy, 0);
        tick(K_RIGHT);
        tick(0);
        tick(0); @(negedge clock);
        chk("t1_chk_req_n2", chk_req, 1);
        chk("t1_chk_col_n2", chk_col, 9);
        tick(0); @(negedge clock);
        chk("t1_piece_col_n3", piece_col, 9);

        // Walk to column 0, then left must be rejected without a check.
        repeat (9) begin tick(K_LEFT); repeat (3) tick(0); end
        @(negedge clock);
        chk("t2_col0", piece_col, 0);
        saw = 1'b0;
        tick(K_LEFT);
        repeat (4) begin tick(0); @(negedge clock); if (chk_req) saw = 1'b1; end
        chk("t2_no_req", saw, 0);
        chk("t2_col_stays0", piece_col, 0);
        tick(K_RIGHT); tick(0); tick(0); @(negedge clock);
        chk("t2_flag_cleared_right_col", chk_col, 1);
        tick(0);

        // Gravity beats left in the same cycle.
        do_reset();
        tick(K_GRAV | K_LEFT); tick(0);
        tick(0); @(negedge clock);
        chk("t3_grav_chk_row", chk_row, 1);
        chk("t3_grav_chk_col", chk_col, 8);
        tick(0); @(negedge clock);
        chk("t3_piece_row1", piece_row, 1);
        tick(0); @(negedge clock);
        chk("t3_left_chk_col", chk_col, 7);
        tick(0); @(negedge clock);
        chk("t3_piece_col7", piece_col, 7);

        // Floor: gravity at row 19 locks, respawns at (0,8,0).
        repeat (18) begin tick(K_GRAV); repeat (3) tick(0); end
        @(negedge clock);
        chk("t4_row19", piece_row, 19);
        tick(K_GRAV); tick(0);
        tick(0); @(negedge clock);
        chk("t4_lock_req", lock_req, 1);
        chk("t4_no_chk_req", chk_req, 0);
        tick(0);
        tick(0); @(negedge clock);
        chk("t4_spawn_chk_req", chk_req, 1);
        chk("t4_spawn_chk_col", chk_col, 8);
        tick(0); @(negedge clock);
        chk("t4_spawn_row", piece_row, 0);
        chk("t4_spawn_col", piece_col, 8);
        chk("t4_spawn_busy", busy, 0);

        // Spawn check fails: game over, requests suppressed.
        pol_spawn_ok_pct = 0;
        repeat (19) begin tick(K_GRAV); repeat (3) tick(0); end
        tick(K_GRAV);
        repeat (6) tick(0);
        @(negedge clock);
        chk("t5_game_over", game_over, 1);
        saw = 1'b0;
        repeat (10) begin
            tick(5'($urandom));
            @(negedge clock);
            if (chk_req || lock_req) saw = 1'b1;
        end
        chk("t5_no_req", saw, 0);
        chk("t5_game_over_sticky", game_over, 1);
        chk("t5_frozen_col", piece_col, 8);
        set_directed();

        // Check timeout on rotate.
        do_reset();
        pol_timeout_pct = 100;
        tick(K_ROT); tick(0);
        cnt = 0; done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            tick(0); @(negedge clock);
            if (chk_req) cnt++; else done = 1'b1;
        end
        chk("t6_req_cycles", cnt, 64);
        chk("t6_chk_err", chk_err, 1);
        chk("t6_rot_unchanged", piece_rot, 0);
        chk("t6_idle", busy, 0);
        pol_timeout_pct = 0;
        repeat (4) begin tick(K_ROT); repeat (3) tick(0); end
        @(negedge clock);
        chk("t6_rot_wrap", piece_rot, 0);
        chk("t6_err_sticky", chk_err, 1);

        // Randomised traffic.
        pol_delay_max = 3; pol_timeout_pct = 3; pol_ok_pct = 70;
        pol_spawn_ok_pct = 90; pol_lock_max = 3;
        do_reset();
        for (int cyc = 0; cyc < 6000; cyc++) begin
            bit [4:0] k;
            for (int b = 0; b < 5; b++) k[b] = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 999) == 0 || (m_mode == M_OVER && $urandom_range(0, 19) == 0))
                do_reset();
            else
                tick(k);
        end
        repeat (2) tick(0);
        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
